pc_sequencer: RTL and testbench

PC_SEQUENCER -- requirements
Module: pc_sequencer

---
 rtl/pc_sequencer.sv | 135 +++++++++++++
 tb/tb_pc_sequencer.sv | 386 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pc_sequencer.sv
// Program counter sequencer with a return-address stack (call/ret), absolute/relative jumps.
// Define PC_STACK_WRAP_EN to let a call on a full stack overwrite the oldest entry.
module pc_sequencer #(
  parameter int unsigned      WIDTH        = 16,
  parameter int unsigned      STACK_DEPTH  = 8,
  parameter logic [WIDTH-1:0] RESET_VECTOR = '0
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [WIDTH-1:0]             dataIn,
  output logic [WIDTH-1:0]             dataOut,
  input  logic                         writeEnable,
  input  logic                         writeAdd,
  input  logic                         countEnable,
  input  logic                         call,
  input  logic                         ret,
  output logic [$clog2(STACK_DEPTH):0] stackCount,
  output logic                         stackFull,
  output logic                         stackEmpty,
  output logic                         stackError
);

  localparam int unsigned     PtrW   = $clog2(STACK_DEPTH);
  localparam int unsigned     CntW   = PtrW + 1;
  localparam logic [CntW-1:0] DepthC = CntW'(STACK_DEPTH);

  typedef enum logic [2:0] {
    ActHold,
    ActCount,
    ActLoad,
    ActCall,
    ActCallFull,
    ActRet,
    ActRetEmpty
  } action_e;

  logic [WIDTH-1:0] pc_q, pc_d;
  logic [PtrW-1:0]  ptr_q, ptr_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic             err_q, err_d;
  logic [WIDTH-1:0] stack_q [STACK_DEPTH];

  action_e          act;
  logic [WIDTH-1:0] pc_inc;
  logic [WIDTH-1:0] target;
  logic [WIDTH-1:0] top;
  logic             push;
  logic             full;
  logic             empty;

  assign full   = (cnt_q == DepthC);
  assign empty  = (cnt_q == '0);
  assign pc_inc = pc_q + WIDTH'(1);
  // Relative mode: unsigned add is the same as signed add modulo 2^WIDTH.
  assign target = writeAdd ? (pc_q + dataIn) : dataIn;
  // ptr_q points at the next free slot; the top entry sits just below it.
  assign top    = stack_q[ptr_q - PtrW'(1)];

  // Priority decode: ret > call > writeEnable > countEnable > hold.
  always_comb begin
    act = ActHold;
    if (ret) begin
      act = empty ? ActRetEmpty : ActRet;
    end else if (call) begin
      act = full ? ActCallFull : ActCall;
    end else if (writeEnable) begin
      act = ActLoad;
    end else if (countEnable) begin
      act = ActCount;
    end
  end

  always_comb begin
    pc_d  = pc_q;
    ptr_d = ptr_q;
    cnt_d = cnt_q;
    err_d = err_q;
    push  = 1'b0;
    unique case (act)
      ActCount: pc_d = pc_inc;
      ActLoad:  pc_d = target;
      ActCall: begin
        pc_d  = target;
        push  = 1'b1;
        ptr_d = ptr_q + PtrW'(1);
        cnt_d = cnt_q + CntW'(1);
      end
      ActCallFull: begin
`ifdef PC_STACK_WRAP_EN
        // Circular overwrite: the slot at ptr_q holds the oldest entry when full.
        pc_d  = target;
        push  = 1'b1;
        ptr_d = ptr_q + PtrW'(1);
`else
        err_d = 1'b1;
`endif
      end
      ActRet: begin
        pc_d  = top;
        ptr_d = ptr_q - PtrW'(1);
        cnt_d = cnt_q - CntW'(1);
      end
      ActRetEmpty: err_d = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_q  <= RESET_VECTOR;
      ptr_q <= '0;
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      pc_q  <= pc_d;
      ptr_q <= ptr_d;
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end

  // Stack contents are not reset; the count alone decides which entries are valid.
  always_ff @(posedge clk) begin
    if (push) begin
      stack_q[ptr_q] <= pc_inc;
    end
  end

  assign dataOut    = pc_q;
  assign stackCount = cnt_q;
  assign stackFull  = full;
  assign stackEmpty = empty;
  assign stackError = err_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer: queue-based reference stack feeds a scoreboard,
// scenario tasks add directed checks on the documented example values.
module tb_pc_sequencer;

  localparam int          W  = 16;
  localparam int          D  = 8;
  localparam logic [15:0] RV = 16'h0040;

  logic        clk;
  logic        reset;
  logic [15:0] dataIn;
  logic [15:0] dataOut;
  logic        writeEnable;
  logic        writeAdd;
  logic        countEnable;
  logic        call;
  logic        ret;
  logic [3:0]  stackCount;
  logic        stackFull;
  logic        stackEmpty;
  logic        stackError;

  pc_sequencer #(
    .WIDTH       (W),
    .STACK_DEPTH (D),
    .RESET_VECTOR(RV)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .dataIn     (dataIn),
    .dataOut    (dataOut),
    .writeEnable(writeEnable),
    .writeAdd   (writeAdd),
    .countEnable(countEnable),
    .call       (call),
    .ret        (ret),
    .stackCount (stackCount),
    .stackFull  (stackFull),
    .stackEmpty (stackEmpty),
    .stackError (stackError)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] pc;
    int          cnt;
    logic        err;
  } exp_t;

  exp_t        sb[$];
  logic [15:0] m_stk[$];
  logic [15:0] m_pc;
  logic        m_err;
  int          checks;
  int          errors;
  exp_t        me;

  task automatic model_reset();
    m_stk.delete();
    m_pc  = RV;
    m_err = 1'b0;
  endtask

  task automatic model_step(input logic we, input logic wa, input logic ce, input logic ca,
                            input logic rt, input logic [15:0] din);
    logic [15:0] tgt;
    tgt = wa ? 16'(m_pc + din) : din;
    if (rt) begin
      if (m_stk.size() > 0) m_pc = m_stk.pop_back();
      else m_err = 1'b1;
    end else if (ca) begin
      if (m_stk.size() < D) begin
        m_stk.push_back(16'(m_pc + 16'd1));
        m_pc = tgt;
      end else begin
`ifdef PC_STACK_WRAP_EN
        void'(m_stk.pop_front());
        m_stk.push_back(16'(m_pc + 16'd1));
        m_pc = tgt;
`else
        m_err = 1'b1;
`endif
      end
    end else if (we) begin
      m_pc = tgt;
    end else if (ce) begin
      m_pc = 16'(m_pc + 16'd1);
    end
  endtask

  // Drive one cycle of stimulus and queue the expected post-edge state.
  task automatic cyc(input logic we, input logic wa, input logic ce, input logic ca,
                     input logic rt, input logic [15:0] din);
    exp_t e;
    writeEnable = we;
    writeAdd    = wa;
    countEnable = ce;
    call        = ca;
    ret         = rt;
    dataIn      = din;
    model_step(we, wa, ce, ca, rt, din);
    e.pc  = m_pc;
    e.cnt = m_stk.size();
    e.err = m_err;
    sb.push_back(e);
    @(posedge clk);
    #2;
    writeEnable = 1'b0;
    writeAdd    = 1'b0;
    countEnable = 1'b0;
    call        = 1'b0;
    ret         = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    #1;
    model_reset();
    @(posedge clk);
    #2;
    reset = 1'b0;
  endtask

  // Scoreboard: compare each edge's outcome against the queued expectation.
  always @(posedge clk) begin
    #1;
    if (sb.size() != 0) begin
      me = sb.pop_front();
      checks++;
      if (dataOut !== me.pc) begin
        errors++;
        $display("FAIL sb_pc: got %h want %h at %0t", dataOut, me.pc, $time);
      end
      checks++;
      if (stackCount !== 4'(me.cnt)) begin
        errors++;
        $display("FAIL sb_count: got %0d want %0d at %0t", stackCount, me.cnt, $time);
      end
      checks++;
      if (stackError !== me.err) begin
        errors++;
        $display("FAIL sb_error: got %b want %b at %0t", stackError, me.err, $time);
      end
      checks++;
      if (stackFull !== (me.cnt == D) || stackEmpty !== (me.cnt == 0)) begin
        errors++;
        $display("FAIL sb_flags: got full=%b empty=%b want count %0d at %0t",
                 stackFull, stackEmpty, me.cnt, $time);
      end
    end
  end

  task automatic test_reset();
    reset = 1'b1;
    #1;
    model_reset();
    checks++;
    if (dataOut !== RV || stackEmpty !== 1'b1 || stackError !== 1'b0) begin
      errors++;
      $display("FAIL reset_noclk: got pc=%h empty=%b err=%b want pc=%h empty=1 err=0",
               dataOut, stackEmpty, stackError, RV);
    end
    call        = 1'b1;
    writeEnable = 1'b1;
    dataIn      = 16'h1234;
    @(posedge clk);
    #2;
    checks++;
    if (dataOut !== RV || stackCount !== 4'd0) begin
      errors++;
      $display("FAIL reset_hold: got pc=%h cnt=%0d want pc=%h cnt=0", dataOut, stackCount, RV);
    end
    call        = 1'b0;
    writeEnable = 1'b0;
    reset       = 1'b0;
  endtask

  task automatic test_load();
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'hDEAD);
    checks++;
    if (dataOut !== 16'hDEAD) begin
      errors++;
      $display("FAIL load_abs: got %h want DEAD", dataOut);
    end
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'h000C);
    cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 16'hFFFC);
    checks++;
    if (dataOut !== 16'h0008) begin
      errors++;
      $display("FAIL load_rel: got %h want 0008", dataOut);
    end
  endtask

  task automatic test_count_wrap();
    logic [15:0] want [3];
    want[0] = 16'hFFFF;
    want[1] = 16'h0000;
    want[2] = 16'h0001;
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'hFFFE);
    for (int i = 0; i < 3; i++) begin
      cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0000);
      checks++;
      if (dataOut !== want[i]) begin
        errors++;
        $display("FAIL count_wrap%0d: got %h want %h", i, dataOut, want[i]);
      end
    end
  endtask

  task automatic test_call_ret();
    do_reset();
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0100);
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0200);
    checks++;
    if (dataOut !== 16'h0200 || stackCount !== 4'd1) begin
      errors++;
      $display("FAIL call: got pc=%h cnt=%0d want pc=0200 cnt=1", dataOut, stackCount);
    end
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0000);
    checks++;
    if (dataOut !== 16'h0101 || stackEmpty !== 1'b1) begin
      errors++;
      $display("FAIL ret: got pc=%h empty=%b want pc=0101 empty=1", dataOut, stackEmpty);
    end
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0000);
    checks++;
    if (dataOut !== 16'h0101 || stackError !== 1'b1) begin
      errors++;
      $display("FAIL ret_empty: got pc=%h err=%b want pc=0101 err=1", dataOut, stackError);
    end
    // Error is sticky but must not block normal operation.
    cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0000);
    checks++;
    if (dataOut !== 16'h0102 || stackError !== 1'b1) begin
      errors++;
      $display("FAIL err_sticky: got pc=%h err=%b want pc=0102 err=1", dataOut, stackError);
    end
    reset = 1'b1;
    #1;
    model_reset();
    checks++;
    if (stackError !== 1'b0 || dataOut !== RV) begin
      errors++;
      $display("FAIL err_clear: got err=%b pc=%h want err=0 pc=%h", stackError, dataOut, RV);
    end
    @(posedge clk);
    #2;
    reset = 1'b0;
  endtask

  task automatic test_overflow();
    logic [15:0] want_pc;
    logic        want_err;
    logic [15:0] want_first;
    logic [15:0] want_last;
`ifdef PC_STACK_WRAP_EN
    want_pc    = 16'h1008;
    want_err   = 1'b0;
    want_first = 16'h1008;
    want_last  = 16'h1001;
`else
    want_pc    = 16'h1007;
    want_err   = 1'b1;
    want_first = 16'h1007;
    want_last  = 16'h0101;
`endif
    do_reset();
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0100);
    for (int n = 0; n < 9; n++) begin
      cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 16'(16'h1000 + n));
    end
    checks++;
    if (dataOut !== want_pc || stackError !== want_err || stackFull !== 1'b1) begin
      errors++;
      $display("FAIL overflow: got pc=%h err=%b full=%b want pc=%h err=%b full=1",
               dataOut, stackError, stackFull, want_pc, want_err);
    end
    for (int n = 0; n < 8; n++) begin
      cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0000);
      if (n == 0) begin
        checks++;
        if (dataOut !== want_first) begin
          errors++;
          $display("FAIL ovf_ret_first: got %h want %h", dataOut, want_first);
        end
      end
    end
    checks++;
    if (dataOut !== want_last || stackEmpty !== 1'b1) begin
      errors++;
      $display("FAIL ovf_ret_last: got pc=%h empty=%b want pc=%h empty=1",
               dataOut, stackEmpty, want_last);
    end
  endtask

  task automatic test_priority();
    do_reset();
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0300);
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0400);
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 16'h0500);
    checks++;
    if (stackCount !== 4'd1 || dataOut !== 16'h0301) begin
      errors++;
      $display("FAIL call_ret_prio: got cnt=%0d pc=%h want cnt=1 pc=0301", stackCount, dataOut);
    end
    cyc(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 16'h0777);
    checks++;
    if (dataOut !== 16'(RV + 16'd1) || stackCount !== 4'd0) begin
      errors++;
      $display("FAIL ret_prio: got pc=%h cnt=%0d want pc=%h cnt=0",
               dataOut, stackCount, 16'(RV + 16'd1));
    end
    // Relative call wins over writeEnable.
    cyc(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 16'h0010);
    checks++;
    if (dataOut !== 16'(RV + 16'h0011) || stackCount !== 4'd1) begin
      errors++;
      $display("FAIL call_rel: got pc=%h cnt=%0d want pc=%h cnt=1",
               dataOut, stackCount, 16'(RV + 16'h0011));
    end
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0600);
    call   = 1'b1;
    dataIn = 16'h0700;
    reset  = 1'b1;
    #1;
    model_reset();
    checks++;
    if (dataOut !== RV || stackCount !== 4'd0) begin
      errors++;
      $display("FAIL reset_mid: got pc=%h cnt=%0d want pc=%h cnt=0", dataOut, stackCount, RV);
    end
    @(posedge clk);
    #2;
    reset = 1'b0;
    call  = 1'b0;
    cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0000);
  endtask

  task automatic test_back_to_back();
    do_reset();
    for (int i = 0; i < 300; i++) begin
      cyc(1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 1)),
          1'($urandom_range(0, 1)), 1'($urandom_range(0, 2) == 0),
          1'($urandom_range(0, 4) == 0), 16'($urandom()));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

  initial begin
    checks      = 0;
    errors      = 0;
    reset       = 1'b0;
    dataIn      = '0;
    writeEnable = 1'b0;
    writeAdd    = 1'b0;
    countEnable = 1'b0;
    call        = 1'b0;
    ret         = 1'b0;
    model_reset();
    #1;
    test_reset();
    test_load();
    test_count_wrap();
    test_call_ret();
    test_overflow();
    test_priority();
    test_back_to_back();
    @(posedge clk);
    #2;
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL sb_drain: got %0d pending want 0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
